// File: rtl/div_unit_seq.sv
// div_unit_seq: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle. Divide-by-zero and signed overflow finish
// without iterating. o_done pulses for exactly one cycle, and o_result is valid
// in that cycle; o_result then holds its value until the next completion.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   arst        asynchronous active-high reset
//   i_start     request; accepted only when idle
//   i_op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend  dividend (rs1)
//   i_divisor   divisor (rs2)
//   o_busy      high while calculating or presenting a result
//   o_done      one-cycle completion pulse
//   o_result    quotient or remainder, selected by i_op
module div_unit_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q, rem_op_q;

    // Request decode: funct3 bit 0 clear means signed, bit 1 set selects remainder.
    logic         op_signed, op_rem, dvd_neg, dvs_neg, div_zero, sgn_ovf, special;
    logic [W-1:0] dvd_abs, dvs_abs, special_res;

    always_comb begin
        op_signed   = ~i_op[0];
        op_rem      = i_op[1];
        dvd_neg     = op_signed & i_dividend[W-1];
        dvs_neg     = op_signed & i_divisor[W-1];
        dvd_abs     = dvd_neg ? W'(-i_dividend) : i_dividend;
        dvs_abs     = dvs_neg ? W'(-i_divisor) : i_divisor;
        div_zero    = (i_divisor == '0);
        sgn_ovf     = op_signed & (i_dividend == {1'b1, {(W-1){1'b0}}}) & (&i_divisor);
        special     = div_zero | sgn_ovf;
        if (div_zero) begin
            special_res = op_rem ? i_dividend : '1;
        end else begin
            special_res = op_rem ? '0 : i_dividend;
        end
    end

    // One restoring step: shift {rem,quo} left, then trial-subtract in W+1 bits.
    logic [W:0]   shifted, trial;
    logic         fits;
    logic [W-1:0] rem_nx, quo_nx, quo_fix, rem_fix, final_res;

    always_comb begin
        shifted   = {rem_q, quo_q[W-1]};
        trial     = shifted - {1'b0, dvs_q};
        fits      = ~trial[W];
        rem_nx    = fits ? trial[W-1:0] : shifted[W-1:0];
        quo_nx    = {quo_q[W-2:0], fits};
        quo_fix   = neg_quo_q ? W'(-quo_nx) : quo_nx;
        rem_fix   = neg_rem_q ? W'(-rem_nx) : rem_nx;
        final_res = rem_op_q ? rem_fix : quo_fix;
    end

    // Next-state and control strobes.
    logic load, load_special, step;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        load_special = 1'b0;
        step         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (special) begin
                        load_special = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, with busy/done registered from the next state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_busy  <= (state_d != S_IDLE);
            o_done  <= (state_d == S_DONE);
        end
    end

    // Datapath: operand capture, iteration and sign-fixed result.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            o_result  <= '0;
        end else begin
            if (load) begin
                rem_q     <= '0;
                quo_q     <= dvd_abs;
                dvs_q     <= dvs_abs;
                cnt_q     <= CNT_W'(W);
                neg_quo_q <= dvd_neg ^ dvs_neg;
                neg_rem_q <= dvd_neg;
                rem_op_q  <= op_rem;
            end else if (step) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (load_special) begin
                o_result <= special_res;
            end else if (step && (cnt_q == CNT_W'(1))) begin
                o_result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// Testbench for div_unit_seq: directed vectors plus a short randomized run,
// checked by a scoreboard queue that a separate monitor drains on o_done.
module tb_div_unit_seq;

    localparam int unsigned W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int LAT_N = W + 1;
    localparam int LAT_S = 1;

    logic         clk = 1'b0;
    logic         arst;
    logic         i_start;
    logic [1:0]   i_op;
    logic [W-1:0] i_dividend, i_divisor;
    logic         o_busy, o_done;
    logic [W-1:0] o_result;

    div_unit_seq #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .arst       (arst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] exp_res[$];
    int           exp_c0[$];
    int           exp_lat[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    endtask

    // Reference RV32M semantics.
    function automatic logic [W-1:0] gold(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W-1:0] mn;
        mn = {1'b1, {(W-1){1'b0}}};
        if (b == '0) return op[1] ? a : '1;
        if (!op[0] && a == mn && b == '1) return op[1] ? '0 : a;
        case (op)
            OP_DIV:  return W'($signed(a) / $signed(b));
            OP_DIVU: return a / b;
            OP_REM:  return W'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int gold_lat(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        if (b == '0) return LAT_S;
        if (!op[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1) return LAT_S;
        return LAT_N;
    endfunction

    // Monitor: pop and compare whenever a result is presented.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (arst) begin
            prev_done = 1'b0;
        end else begin
            if (o_done) begin
                chk("done_one_cycle", W'(prev_done), W'(0));
                if (exp_res.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got result %h with nothing expected (t=%0t)",
                             o_result, $time);
                end else begin
                    logic [W-1:0] r;
                    int           c0, lat;
                    r   = exp_res.pop_front();
                    c0  = exp_c0.pop_front();
                    lat = exp_lat.pop_front();
                    chk("result", o_result, r);
                    chk("latency", W'(cyc - c0 + 1), W'(lat));
                end
            end
            prev_done = o_done;
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_busy && !o_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL wait_idle: got busy=%b expected 0 within 100 cycles", o_busy);
        end
    endtask

    // Issue one request at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] expv, input int lat, input bit push);
        wait_idle();
        i_start    = 1'b1;
        i_op       = op;
        i_dividend = a;
        i_divisor  = b;
        if (push) begin
            exp_res.push_back(expv);
            exp_c0.push_back(cyc + 1);
            exp_lat.push_back(lat);
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] corners [6];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h2;

        arst       = 1'b1;
        i_start    = 1'b0;
        i_op       = '0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_done", W'(o_done), W'(0));
        chk("rst_result", o_result, '0);
        arst = 1'b0;

        // DIVU 100/7 with busy profile across the whole operation.
        start_op(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, 1'b1);
        chk("busy_e1", W'(o_busy), W'(1));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("busy_calc", W'(o_busy), W'(1));
        end
        @(negedge clk);
        chk("busy_after", W'(o_busy), W'(0));

        // Signed/unsigned sign-fix cases.
        start_op(OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT_N, 1'b1);
        start_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT_N, 1'b1);
        start_op(OP_REMU, 32'hFFFF_FFF9, 32'd2,        32'd1,         LAT_N, 1'b1);
        start_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N, 1'b1);
        start_op(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_N, 1'b1);
        start_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         LAT_N, 1'b1);
        start_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_N, 1'b1);

        // Divide-by-zero and signed overflow.
        start_op(OP_DIVU, 32'd5,         32'd0,        32'hFFFF_FFFF, LAT_S, 1'b1);
        start_op(OP_REMU, 32'd5,         32'd0,        32'd5,         LAT_S, 1'b1);
        start_op(OP_REM,  32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, LAT_S, 1'b1);
        start_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S, 1'b1);
        start_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_S, 1'b1);

        // Ignored starts mid-CALC and in DONE, operand changes after accept.
        start_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT_N, 1'b1);
        i_dividend = 32'd12345;
        i_divisor  = 32'd5;
        repeat (4) @(negedge clk);
        i_start    = 1'b1;
        i_op       = OP_REMU;
        i_dividend = 32'd9;
        i_divisor  = 32'd4;
        @(negedge clk);
        i_start = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (o_done) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("done_seen", W'(seen), W'(1));
        end
        i_start    = 1'b1;
        i_op       = OP_DIVU;
        i_dividend = 32'd123;
        i_divisor  = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        chk("ignore_done_busy", W'(o_busy), W'(0));
        chk("hold_result", o_result, 32'd100);
        repeat (3) @(negedge clk);
        chk("hold_busy", W'(o_busy), W'(0));
        chk("hold_result2", o_result, 32'd100);
        start_op(OP_DIVU, 32'd77, 32'd7, 32'd11, LAT_N, 1'b1);
        repeat (10) @(negedge clk);
        chk("hold_during_calc", o_result, 32'd100);

        // Asynchronous reset in the middle of an operation.
        start_op(OP_DIV, 32'd1000, 32'd3, 32'd0, LAT_N, 1'b0);
        repeat (15) @(negedge clk);
        @(posedge clk);
        #2 arst = 1'b1;
        #1;
        chk("arst_busy", W'(o_busy), W'(0));
        chk("arst_done", W'(o_done), W'(0));
        chk("arst_result", o_result, '0);
        @(negedge clk);
        arst = 1'b0;
        start_op(OP_DIV, 32'd42, 32'hFFFF_FFFA, 32'hFFFF_FFF9, LAT_N, 1'b1);

        // Randomized operands with corner values mixed in.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            case ($urandom_range(0, 4))
                0:       b = corners[$urandom_range(0, 5)];
                1:       b = W'($urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            start_op(op, a, b, gold(op, a, b), gold_lat(op, a, b), 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", W'(exp_res.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
